result_accumulator: RTL and testbench

RESULT_ACCUMULATOR -- requirements
Module: result_accumulator

---
 rtl/datapath_pkg.sv | 18 +
 rtl/acc_saturate.sv | 25 ++
 rtl/result_accumulator.sv | 117 +++++++++++
 tb/tb_result_accumulator.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - shared types and sizing for the result accumulator
package datapath_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      EMIT  = 2'd2
   } state_t;

   localparam int N_DEFAULT     = 16;
   localparam int BATCH_DEFAULT = 4;

   // Wide enough that BATCH full-scale results can never overflow the sum
   function automatic int acc_width(input int n, input int batch);
      return n + $clog2(batch);
   endfunction

endpackage

// File: rtl/acc_saturate.sv
// rtl/acc_saturate.sv - clips a wide signed accumulator into N signed bits
module acc_saturate #(
   parameter int ACC_W = 18,
   parameter int N     = 16
) (
   input  logic signed [ACC_W-1:0] acc,
   output logic signed [N-1:0]     sum,
   output logic                    sat
);

   logic [ACC_W-N:0] upper;

   // In range only when every bit above the result's sign bit copies it
   always_comb begin
      upper = acc[ACC_W-1:N-1];
      sat   = !((upper == '0) || (upper == '1));
      if (!sat)
         sum = acc[N-1:0];
      else if (acc[ACC_W-1])
         sum = {1'b1, {(N-1){1'b0}}};
      else
         sum = {1'b0, {(N-1){1'b1}}};
   end

endmodule

// File: rtl/result_accumulator.sv
// rtl/result_accumulator.sv - sums batches of datapath results with saturation
module result_accumulator
   import datapath_pkg::*;
#(
   parameter  int N     = N_DEFAULT,
   parameter  int BATCH = BATCH_DEFAULT,
   localparam int ACC_W = acc_width(N, BATCH),
   localparam int CNT_W = $clog2(BATCH) + 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [N-1:0]     Y,
   input  logic                    co,
   input  logic                    flush,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [N-1:0]     out_sum,
   output logic                    out_sat,
   output logic [CNT_W-1:0]        out_cnt,
   output logic [CNT_W-1:0]        out_carries
);

   state_t                   state, state_next;
   logic signed [ACC_W-1:0]  acc, acc_next, y_ext;
   logic [CNT_W-1:0]         cnt, cnt_next;
   logic [CNT_W-1:0]         carries, carries_next;
   logic                     accept;
   logic signed [N-1:0]      sat_sum;
   logic                     sat_flag;

   assign y_ext  = {{(ACC_W-N){Y[N-1]}}, Y};
   assign accept = in_valid && in_ready;

   // Saturate the value the accumulator is about to hold, so it can be
   // captured into the output registers on the same edge that enters EMIT
   acc_saturate #(
      .ACC_W (ACC_W),
      .N     (N)
   ) u_sat (
      .acc (acc_next),
      .sum (sat_sum),
      .sat (sat_flag)
   );

   // State, accumulator and counters; outputs captured on entry to EMIT
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         acc         <= '0;
         cnt         <= '0;
         carries     <= '0;
         out_sum     <= '0;
         out_sat     <= 1'b0;
         out_cnt     <= '0;
         out_carries <= '0;
      end else begin
         state   <= state_next;
         acc     <= acc_next;
         cnt     <= cnt_next;
         carries <= carries_next;
         if (state != EMIT && state_next == EMIT) begin
            out_sum     <= sat_sum;
            out_sat     <= sat_flag;
            out_cnt     <= cnt_next;
            out_carries <= carries_next;
         end
      end
   end

   // Next state and next accumulator/counter values
   always_comb begin
      state_next   = state;
      acc_next     = acc;
      cnt_next     = cnt;
      carries_next = carries;
      case (state)
         IDLE, ACCUM: begin
            if (accept) begin
               if (state == IDLE) begin
                  acc_next     = y_ext;
                  cnt_next     = CNT_W'(1);
                  carries_next = CNT_W'(co);
               end else begin
                  acc_next     = acc + y_ext;
                  cnt_next     = cnt + CNT_W'(1);
                  carries_next = carries + CNT_W'(co);
               end
            end
            // A lone flush in IDLE has nothing to emit and is dropped
            if (accept || state == ACCUM) begin
               if (cnt_next == CNT_W'(BATCH) || flush)
                  state_next = EMIT;
               else
                  state_next = ACCUM;
            end
         end
         EMIT: begin
            if (out_ready) begin
               state_next   = IDLE;
               acc_next     = '0;
               cnt_next     = '0;
               carries_next = '0;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Handshake outputs decoded from state; no accept while emitting
   always_comb begin
      in_ready  = (state != EMIT);
      out_valid = (state == EMIT);
   end

endmodule

// File: tb/tb_result_accumulator.sv
// tb/tb_result_accumulator.sv - scoreboard bench for result_accumulator
module tb_result_accumulator;

   localparam int N     = 16;
   localparam int BATCH = 4;
   localparam int CNT_W = 3;

   logic                clk = 1'b0;
   logic                rst, in_valid, in_ready, co, flush;
   logic                out_valid, out_ready, out_sat;
   logic signed [N-1:0] y, out_sum;
   logic [CNT_W-1:0]    out_cnt, out_carries;

   always #5 clk = ~clk;

   result_accumulator #(.N(N), .BATCH(BATCH)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .Y           (y),
      .co          (co),
      .flush       (flush),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_sum     (out_sum),
      .out_sat     (out_sat),
      .out_cnt     (out_cnt),
      .out_carries (out_carries)
   );

   typedef struct {
      int sum;
      int sat;
      int cnt;
      int car;
   } res_t;

   res_t exp_q[$];
   res_t last_out;
   int   batch_y[$];
   int   batch_car;
   bit   emitting;
   bit   mon_en;
   int   checks;
   int   errors;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic res_t close_batch();
      res_t   r;
      longint s = 0;
      foreach (batch_y[i]) s += batch_y[i];
      r.sat = (s > 32767 || s < -32768) ? 1 : 0;
      r.sum = (s > 32767) ? 32767 : (s < -32768) ? -32768 : int'(s);
      r.cnt = batch_y.size();
      r.car = batch_car;
      return r;
   endfunction

   // Reference behaviour applied at each rising edge to the inputs present there
   task automatic model_edge();
      if (rst) begin
         batch_y.delete();
         batch_car = 0;
         emitting  = 1'b0;
         exp_q.delete();
         last_out  = '{0, 0, 0, 0};
      end else if (emitting) begin
         if (out_ready) emitting = 1'b0;
      end else begin
         if (in_valid) begin
            batch_y.push_back(int'(y));
            batch_car += int'(co);
         end
         if (batch_y.size() == BATCH || (flush && batch_y.size() > 0)) begin
            exp_q.push_back(close_batch());
            batch_y.delete();
            batch_car = 0;
            emitting  = 1'b1;
         end
      end
   endtask

   task automatic step(input bit v, input int yv, input bit c, input bit f,
                       input bit r, input bit rs);
      in_valid  = v;
      y         = 16'(yv);
      co        = c;
      flush     = f;
      out_ready = r;
      rst       = rs;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   // Monitor: compares DUT outputs against the scoreboard away from the edge
   initial begin
      forever begin
         @(negedge clk);
         if (mon_en) begin
            chk("out_valid", int'(out_valid), int'(emitting));
            chk("in_ready", int'(in_ready), int'(!emitting));
            if (out_valid) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_emit", 1, 0);
               end else begin
                  chk("out_sum", int'(out_sum), exp_q[0].sum);
                  chk("out_sat", int'(out_sat), exp_q[0].sat);
                  chk("out_cnt", int'(out_cnt), exp_q[0].cnt);
                  chk("out_carries", int'(out_carries), exp_q[0].car);
                  if (out_ready) last_out = exp_q.pop_front();
               end
            end else begin
               chk("hold_sum", int'(out_sum), last_out.sum);
               chk("hold_sat", int'(out_sat), last_out.sat);
               chk("hold_cnt", int'(out_cnt), last_out.cnt);
               chk("hold_carries", int'(out_carries), last_out.car);
            end
         end
      end
   end

   initial begin
      int yv;
      checks   = 0;
      errors   = 0;
      mon_en   = 1'b0;
      last_out = '{0, 0, 0, 0};
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      mon_en = 1'b1;
      step(0, 0, 0, 0, 0, 0);

      // Basic batch with mixed carries
      step(1, 10, 0, 0, 0, 0);
      step(1, 20, 1, 0, 0, 0);
      step(1, -5, 1, 0, 0, 0);
      step(1, 7, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0);

      // Positive and negative saturation
      repeat (4) step(1, 30000, 1, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0);
      repeat (4) step(1, -30000, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0);

      // Partial batch flushed, then a lone flush in IDLE
      step(1, 3, 0, 0, 0, 0);
      step(1, 4, 1, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0);

      // Flush together with the first acceptance: one-element batch
      step(1, -9, 1, 1, 0, 0);
      step(0, 0, 0, 0, 1, 0);

      // Stall in EMIT with inputs offered
      repeat (4) step(1, 100, 0, 0, 0, 0);
      repeat (5) step(1, 555, 1, 1, 0, 0);
      step(1, 555, 1, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0);

      // Reset mid-batch discards the partial sum
      repeat (3) step(1, 50, 1, 0, 0, 0);
      step(0, 0, 0, 0, 1, 1);
      repeat (4) step(1, 1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0);

      // Reset while emitting
      repeat (4) step(1, 77, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0)
            yv = ($urandom_range(0, 1) == 1) ? 30000 + int'($urandom_range(0, 2767))
                                             : -30000 - int'($urandom_range(0, 2768));
         else
            yv = int'($urandom_range(0, 65535)) - 32768;
         step($urandom_range(0, 9) < 7, yv, $urandom_range(0, 1) == 1,
              $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 6,
              $urandom_range(0, 149) == 0);
      end

      repeat (6) step(0, 0, 0, 0, 1, 0);
      chk("queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
